// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a one-word holding register.
// Optional even-parity bit after each word when SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Valid_in,
    output logic             Ready_out,
    output logic             Serial_out,
    output logic             Busy_out,
    output logic             Done_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
`ifndef SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             serial_q, serial_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept;
    logic             load_en;
    logic             word_end;
    logic [WIDTH-1:0] load_w;

    assign Ready_out  = ~full_q & ~Reset;
    assign accept     = Valid_in & Ready_out;
    assign Serial_out = serial_q;
    assign Busy_out   = busy_q;
    assign Done_out   = done_q;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        serial_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        load_en  = 1'b0;
        load_w   = Data_in;
        word_end = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d    = par_q;
`endif

        unique case (state_q)
            IDLE: load_en = accept;
            SHIFT: begin
                if (cnt_q == LAST) begin
`ifdef SERIALIZER_PARITY_EN
                    state_d  = PAR;
                    serial_d = par_q;
                    done_d   = 1'b1;
`else
                    word_end = 1'b1;
`endif
                end else begin
                    // shreg_q[MSB] always holds the next bit to emit
                    serial_d = shreg_q[WIDTH-1];
                    shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d    = cnt_q + ONE;
`ifndef SERIALIZER_PARITY_EN
                    done_d   = (cnt_q == PRE);
`endif
                end
            end
            PAR:     word_end = 1'b1;
            default: state_d  = IDLE;
        endcase

        if (state_q != IDLE && !word_end && accept) begin
            hold_d = Data_in;
            full_d = 1'b1;
        end

        if (word_end) begin
            if (full_q) begin
                load_en = 1'b1;
                load_w  = hold_q;
                full_d  = 1'b0;
            end else if (accept) begin
                load_en = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (load_en) begin
            state_d  = SHIFT;
            serial_d = load_w[WIDTH-1];
            shreg_d  = {load_w[WIDTH-2:0], 1'b0};
            cnt_d    = '0;
            done_d   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_d    = ^load_w;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIALIZER_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: bit-stream queue model, directed words, random traffic.
// Builds with or without SERIALIZER_PARITY_EN.
module tb_bit_serializer;

    localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int PB = 1;
    localparam logic [17:0] E_A53C = 18'b10100101_0_00111100_0;
    localparam logic [8:0]  E_A5   = 9'b10100101_0;
    localparam logic [8:0]  E_07   = 9'b00000111_1;
    localparam logic [8:0]  E_03   = 9'b00000011_0;
`else
    localparam int PB = 0;
    localparam logic [15:0] E_A53C = 16'hA53C;
    localparam logic [7:0]  E_A5   = 8'hA5;
    localparam logic [7:0]  E_07   = 8'h07;
    localparam logic [7:0]  E_03   = 8'h03;
`endif
    localparam int L = WIDTH + PB;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [WIDTH-1:0] Data_in;
    logic             Valid_in;
    logic             Ready_out;
    logic             Serial_out;
    logic             Busy_out;
    logic             Done_out;

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Data_in(Data_in),
        .Valid_in(Valid_in),
        .Ready_out(Ready_out),
        .Serial_out(Serial_out),
        .Busy_out(Busy_out),
        .Done_out(Done_out)
    );

    always #10 Clock = ~Clock;

    int nchecks = 0;
    int nerr = 0;
    int acc_cnt = 0;
    int dut_done = 0;
    bit chk_on = 1'b0;
    logic [63:0] cap = '0;

    // Model: future output bits as {done, bit}; ready while no whole word waits.
    logic [1:0] q[$];
    logic cur_b = 1'b0, cur_busy = 1'b0, cur_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nchecks++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(posedge Clock) begin
        logic rdy;
        logic [1:0] e;
        rdy = !Reset && (q.size() < L);
        if (Reset) begin
            q.delete();
            cur_b = 1'b0;
            cur_busy = 1'b0;
            cur_done = 1'b0;
        end else begin
            if (Valid_in && rdy) begin
                acc_cnt++;
                for (int i = WIDTH - 1; i >= 0; i--)
                    q.push_back({(i == 0) && (PB == 0), Data_in[i]});
                if (PB == 1) q.push_back({1'b1, ^Data_in});
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                cur_b = e[0];
                cur_done = e[1];
                cur_busy = 1'b1;
            end else begin
                cur_b = 1'b0;
                cur_done = 1'b0;
                cur_busy = 1'b0;
            end
        end
    end

    always @(negedge Clock) begin
        if (chk_on) begin
            chk("ready", Ready_out, !Reset && (q.size() < L));
            chk("serial", Serial_out, cur_b);
            chk("busy", Busy_out, cur_busy);
            chk("done", Done_out, cur_done);
            cap = {cap[62:0], Serial_out};
            if (Done_out === 1'b1) dut_done++;
        end
    end

    task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] d);
        Reset = r;
        Valid_in = v;
        Data_in = d;
        @(posedge Clock);
        @(negedge Clock);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    initial begin
        int base_acc, base_done;
        Reset = 1'b1;
        Valid_in = 1'b0;
        Data_in = '0;
        @(posedge Clock);
        @(negedge Clock);
        #2;
        chk_on = 1'b1;
        chk("rst_ready", Ready_out, 1'b0);
        chk("rst_serial", Serial_out, 1'b0);
        chk("rst_busy", Busy_out, 1'b0);
        drive(1'b1, 1'b1, 8'h55);
        Reset = 1'b0;
        Valid_in = 1'b0;
        #1;
        chk("rel_ready", Ready_out, 1'b1);

        drive(1'b0, 1'b1, 8'hA5);
        idle(L - 1);
        chk("a5_bits", 32'(cap[L-1:0]), 32'(E_A5));
        chk("a5_done", Done_out, 1'b1);
        idle(1);
        chk("a5_busy_after", Busy_out, 1'b0);
        idle(2);

        drive(1'b0, 1'b1, 8'hA5);
        drive(1'b0, 1'b1, 8'h3C);
        chk("held_ready", Ready_out, 1'b0);
        idle(2 * L - 2);
        chk("b2b_bits", 32'(cap[2*L-1:0]), 32'(E_A53C));
        idle(3);

        drive(1'b0, 1'b1, 8'h07);
        idle(L - 1);
        chk("w07_bits", 32'(cap[L-1:0]), 32'(E_07));
        chk("w07_done", Done_out, 1'b1);
        idle(1);
        drive(1'b0, 1'b1, 8'h03);
        idle(L - 1);
        chk("w03_bits", 32'(cap[L-1:0]), 32'(E_03));
        chk("w03_done", Done_out, 1'b1);
        idle(2);

        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'h0F);
        drive(1'b0, 1'b1, 8'h0F);
        drive(1'b1, 1'b1, 8'h0F);
        chk("rst_mid_serial", Serial_out, 1'b0);
        chk("rst_mid_busy", Busy_out, 1'b0);
        chk("rst_mid_prefix", 32'(cap[3:1]), 32'h7);
        Reset = 1'b0;
        Valid_in = 1'b0;
        #1;
        chk("rst_mid_ready", Ready_out, 1'b1);
        idle(3 * L);
        chk("no_0f", 32'(cap[3*L-1:0]), 32'h0);

        drive(1'b0, 1'b1, 8'hA5);
        idle(L - 1);
        drive(1'b0, 1'b1, 8'h3C);
        idle(L - 1);
        chk("bypass_bits", 32'(cap[2*L-1:0]), 32'(E_A53C));
        idle(3);

        base_acc = acc_cnt;
        base_done = dut_done;
        repeat (800) drive(1'b0, ($urandom % 2) == 1, WIDTH'($urandom));
        idle(3 * L);
        chk("count_eq", dut_done - base_done, acc_cnt - base_acc);

        repeat (2000)
            drive(($urandom % 60) == 0, ($urandom % 3) != 0, WIDTH'($urandom));
        idle(3 * L);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits; legal range 2..32.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Data_in, input, WIDTH bits: parallel word to serialize.
REQ-005 The block SHALL have port Valid_in, input, 1 bit: Data_in is valid.
REQ-006 The block SHALL have port Ready_out, output, 1 bit: block can accept a word.
REQ-007 The block SHALL have port Serial_out, output, 1 bit: serial bit stream feeding the downstream FSM's Din.
REQ-008 The block SHALL have port Busy_out, output, 1 bit: a word is being transmitted.
REQ-009 The block SHALL have port Done_out, output, 1 bit: last bit of a word is on Serial_out.

Function
REQ-010 A word SHALL be accepted on a rising edge where Valid_in=1 and Ready_out=1; no other condition accepts a word.
REQ-011 Ready_out SHALL be the inverse of the holding-register-full flag, gated to 0 while Reset=1.
REQ-012 The FSM SHALL have states IDLE, SHIFT and PAR; PAR is reachable only with the Configuration feature compiled in.
REQ-013 In IDLE, an accepted word SHALL load directly into the shift register, clear the bit counter and move to SHIFT.
REQ-014 Latency: for a word accepted at edge k, Serial_out SHALL carry Data_in[WIDTH-1] (MSB first) during cycle k+1, and bit WIDTH-1-i during cycle k+1+i.
REQ-015 In SHIFT, each edge SHALL shift left by one and increment the counter; the counter SHALL wrap to 0 on word reload.
REQ-016 A word accepted while in SHIFT or PAR SHALL go into the one-entry holding register and set the full flag.
REQ-017 At the edge ending a word's final bit, the FSM SHALL act as follows, in order of precedence:
- If the holding register is full, it SHALL load the held word, clear the flag and stay in SHIFT.
- Else, if a word is accepted on the same edge, that word SHALL bypass the holding register straight into the shift register.
- Else, it SHALL go to IDLE.
REQ-018 Back-to-back words SHALL produce a gapless bit stream with no idle cycle.
REQ-019 In IDLE, Serial_out SHALL be 0.
REQ-020 Busy_out SHALL be 1 exactly in SHIFT and PAR.
REQ-021 Done_out SHALL pulse high for one cycle, coincident with a word's final serial bit.
REQ-022 Valid_in while Ready_out=0 SHALL be ignored; a word held on Data_in/Valid_in SHALL be accepted exactly once, when Ready_out rises.
REQ-023 All outputs except Ready_out SHALL be registered.

Reset
REQ-024 While Reset=1 at a rising edge, the following SHALL hold:
- State goes to IDLE.
- Shift register, counter, holding register and full flag are cleared.
- Serial_out=0, Busy_out=0, Done_out=0.
REQ-025 Reset mid-word SHALL abort the word and discard any held word; Ready_out SHALL be 1 on the first cycle after Reset deasserts.

Configuration
REQ-026 With macro SERIALIZER_PARITY_EN defined, each word SHALL be followed by one PAR cycle carrying the even-parity bit, equal to the XOR of all data bits. Done_out SHALL pulse on the parity bit, and the REQ-017 decision SHALL be taken at the end of PAR.
REQ-027 Without SERIALIZER_PARITY_EN, PAR logic SHALL be absent and words SHALL be exactly WIDTH bits.

Verification
REQ-028 The bench SHALL cover the following directed scenarios (20 ns clock period):
- WIDTH=8, no parity: reset, then accept 8'hA5 -> Serial_out 1,0,1,0,0,1,0,1 in cycles 1-8; Done_out high in cycle 8; Busy_out low from cycle 9.
- Valid_in held high with 8'hA5, then 8'h3C -> 16 contiguous bits 10100101 00111100. Ready_out is low from the accept of 8'h3C until its reload edge.
- SERIALIZER_PARITY_EN defined: 8'h07 -> 00000111 then parity 1; 8'h03 -> 00000011 then parity 0. Done_out is high on each parity bit.
- Reset asserted after 3 bits of 8'hFF, with 8'h0F held -> next cycle Serial_out=0, Busy_out=0; after release Ready_out=1 and 8'h0F is never transmitted.
- Accept on the edge ending the final bit with the holding register empty -> next word's MSB appears in the very next cycle, with no gap.
- Valid_in toggled while Ready_out=0 -> no word is duplicated or lost; transmitted count equals accepted count.
